// File: rtl/cpu_ram_ctrl.sv
// ---------------------------------------------------------------------------
// cpu_ram_ctrl
//
// Purpose: shares one single-port RAM between the instruction and data ports
// of a CPU. A request is arbitrated in IDLE, with data winning over
// instruction. The chosen request is latched and presented to the RAM until
// mem_ack arrives or the wait limit TMO expires. A completion is reported
// back to the CPU only if the live request still matches the one that was
// latched. Otherwise the controller returns to IDLE and re-arbitrates.
//
// States:
//   state | meaning
//   ------+----------------------------------------------------------
//   IDLE  | no RAM access; arbitrate and latch the next request
//   DACC  | data access outstanding; mem_req held, waiting for mem_ack
//   IACC  | instruction access outstanding; mem_req held, waiting
//
// Parameters:
//   ADDR_W  RAM word-address width
//   TMO     cycles to wait for mem_ack before the access times out (1..255)
//
// Ports:
//   clk                     rising-edge clock
//   rst                     synchronous active-high reset
//   iren, iaddr             instruction read request
//   iload, iwait            instruction data / not-yet-complete
//   dren, dwen, daddr       data request (dwen = byte enables, nonzero = write)
//   dstore                  lane-aligned store data
//   dload, dwait            data read result / not-yet-complete
//   mem_req, mem_we         RAM request / byte write enables (0 = read)
//   mem_addr, mem_wdata     RAM word address / write data
//   mem_rdata, mem_ack      RAM read data / one-cycle completion pulse
//   err                     sticky timeout flag, cleared only by rst
// ---------------------------------------------------------------------------
module cpu_ram_ctrl #(
    parameter int ADDR_W = 14,
    parameter int TMO    = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              iren,
    input  logic [31:0]       iaddr,
    output logic [31:0]       iload,
    output logic              iwait,
    input  logic              dren,
    input  logic [3:0]        dwen,
    input  logic [31:0]       daddr,
    input  logic [31:0]       dstore,
    output logic [31:0]       dload,
    output logic              dwait,
    output logic              mem_req,
    output logic [3:0]        mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack,
    output logic              err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DACC = 2'd1,
        IACC = 2'd2
    } state_t;

    localparam logic [7:0]  TMO_CNT  = 8'(TMO);
    localparam logic [31:0] TMO_DATA = 32'hDEADBEEF;

    state_t      state, state_nx;
    logic [29:0] lat_word, lat_word_nx;
    logic [3:0]  lat_we, lat_we_nx;
    logic [31:0] lat_wdata, lat_wdata_nx;
    logic [7:0]  cnt, cnt_nx;
    logic        err_nx;

    logic        busy;
    logic        dreq;
    logic        d_match;
    logic        i_match;
    logic        tmo_hit;
    logic        finish;
    logic        d_done;
    logic        i_done;
    logic [31:0] done_data;

    // Byte offsets never reach the word-addressed RAM.
    logic unused_lsbs;
    assign unused_lsbs = ^{iaddr[1:0], daddr[1:0]};

    // ------------------------------------------------------------------
    // State and latch registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            lat_word  <= '0;
            lat_we    <= '0;
            lat_wdata <= '0;
            cnt       <= '0;
            err       <= 1'b0;
        end else begin
            state     <= state_nx;
            lat_word  <= lat_word_nx;
            lat_we    <= lat_we_nx;
            lat_wdata <= lat_wdata_nx;
            cnt       <= cnt_nx;
            err       <= err_nx;
        end
    end

    // ------------------------------------------------------------------
    // Request qualification
    // ------------------------------------------------------------------
    assign busy    = (state == DACC) || (state == IACC);
    assign dreq    = dren || (dwen != 4'b0000);

    // A completion is only handed back if the CPU is still asking for the
    // same thing. Otherwise the RAM result is stale and gets dropped.
    assign d_match = dreq && (daddr[31:2] == lat_word) && (dwen == lat_we);
    assign i_match = iren && (iaddr[31:2] == lat_word);

    // A real ack wins over a timeout that lands in the same cycle.
    assign tmo_hit = busy && !mem_ack && (cnt == TMO_CNT);
    assign finish  = busy && !rst && (mem_ack || tmo_hit);

    assign d_done  = finish && (state == DACC) && d_match;
    assign i_done  = finish && (state == IACC) && i_match;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_nx     = state;
        lat_word_nx  = lat_word;
        lat_we_nx    = lat_we;
        lat_wdata_nx = lat_wdata;
        cnt_nx       = cnt;
        err_nx       = err;

        case (state)
            IDLE: begin
                if (dreq) begin
                    state_nx     = DACC;
                    lat_word_nx  = daddr[31:2];
                    lat_we_nx    = dwen;
                    lat_wdata_nx = dstore;
                    cnt_nx       = '0;
                end else if (iren) begin
                    state_nx     = IACC;
                    lat_word_nx  = iaddr[31:2];
                    lat_we_nx    = 4'b0000;
                    cnt_nx       = '0;
                end
            end

            DACC, IACC: begin
                if (mem_ack) begin
                    state_nx = IDLE;
                end else if (cnt == TMO_CNT) begin
                    // Abandon the access. Any ack that shows up later
                    // arrives in IDLE and is ignored there.
                    state_nx = IDLE;
                    err_nx   = 1'b1;
                end else begin
                    cnt_nx = cnt + 8'd1;
                end
            end

            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign done_data = tmo_hit ? TMO_DATA : mem_rdata;

    assign dload     = d_done ? done_data : 32'h0;
    assign iload     = i_done ? done_data : 32'h0;
    assign dwait     = dreq && !d_done;
    assign iwait     = iren && !i_done;

    assign mem_req   = busy && !rst;
    assign mem_we    = ((state == DACC) && !rst) ? lat_we : 4'b0000;
    assign mem_addr  = lat_word[ADDR_W-1:0];
    assign mem_wdata = lat_wdata;

endmodule

// File: tb/tb_cpu_ram_ctrl.sv
// ---------------------------------------------------------------------------
// tb_cpu_ram_ctrl
//
// Bench for cpu_ram_ctrl. The CPU side is driven with directed and random
// requests. A bench RAM responds to the controller's outputs. A separate
// reference memory is updated from the CPU-side intent, and it predicts
// every load value.
// ---------------------------------------------------------------------------
module tb_cpu_ram_ctrl;

    localparam int AW  = 14;
    localparam int TMO = 255;

    logic          clk = 1'b0;
    logic          rst;
    logic          iren;
    logic [31:0]   iaddr;
    logic [31:0]   iload;
    logic          iwait;
    logic          dren;
    logic [3:0]    dwen;
    logic [31:0]   daddr;
    logic [31:0]   dstore;
    logic [31:0]   dload;
    logic          dwait;
    logic          mem_req;
    logic [3:0]    mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;
    logic          mem_ack;
    logic          err;

    int total = 0;
    int bad   = 0;

    logic [31:0] ram     [int];
    logic [31:0] ref_mem [int];

    cpu_ram_ctrl #(.ADDR_W(AW), .TMO(TMO)) dut (
        .clk       (clk),
        .rst       (rst),
        .iren      (iren),
        .iaddr     (iaddr),
        .iload     (iload),
        .iwait     (iwait),
        .dren      (dren),
        .dwen      (dwen),
        .daddr     (daddr),
        .dstore    (dstore),
        .dload     (dload),
        .dwait     (dwait),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] we);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++)
            if (we[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    function automatic logic [31:0] rd_ref(input int w);
        return ref_mem.exists(w) ? ref_mem[w] : 32'h0;
    endfunction

    function automatic logic [31:0] rd_ram(input int w);
        return ram.exists(w) ? ram[w] : 32'h0;
    endfunction

    task automatic preload(input int w, input logic [31:0] v);
        ram[w]     = v;
        ref_mem[w] = v;
    endtask

    task automatic release_all();
        iren    = 1'b0;
        dren    = 1'b0;
        dwen    = 4'b0000;
        mem_ack = 1'b0;
    endtask

    // One complete access from an idle controller. The RAM acks dly cycles
    // after mem_req first rises (dly >= 1). The request is dropped in the
    // cycle after completion.
    task automatic acc(input bit is_d, input logic [31:0] addr, input bit rd,
                       input logic [3:0] we, input logic [31:0] wd, input int dly);
        logic [31:0] exp_ld;
        logic [31:0] rdv;
        logic        ack;
        int          w;
        w = int'(addr[AW+1:2]);
        if (is_d) begin
            dren = rd; dwen = we; daddr = addr; dstore = wd;
        end else begin
            iren = 1'b1; iaddr = addr;
        end
        mem_ack = 1'b0;
        sample();
        check("c0_req", 32'(mem_req), 32'h0);
        check("c0_wait", 32'(is_d ? dwait : iwait), 32'h1);
        for (int k = 1; k <= dly + 1; k++) begin
            step();
            ack       = (k == dly + 1);
            mem_ack   = ack;
            rdv       = ack ? rd_ram(int'(mem_addr)) : $urandom;
            mem_rdata = rdv;
            exp_ld    = (is_d && we != 4'b0000) ? rdv : rd_ref(w);
            sample();
            check("req", 32'(mem_req), 32'h1);
            check("addr", 32'(mem_addr), 32'(addr[AW+1:2]));
            check("we", 32'(mem_we), 32'(is_d ? we : 4'b0000));
            if (is_d && we != 4'b0000) check("wdata", mem_wdata, wd);
            check("wait", 32'(is_d ? dwait : iwait), ack ? 32'h0 : 32'h1);
            check("load", is_d ? dload : iload, ack ? exp_ld : 32'h0);
            if (ack && mem_we != 4'b0000)
                ram[int'(mem_addr)] = merge(rd_ram(int'(mem_addr)), mem_wdata, mem_we);
        end
        if (is_d && we != 4'b0000) ref_mem[w] = merge(rd_ref(w), wd, we);
        step();
        release_all();
        sample();
        check("after_req", 32'(mem_req), 32'h0);
        step();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] vd, vi, rv;
        logic [3:0]  we;
        logic [31:0] addr;
        bit          is_d, rd, ok;

        rst = 1'b1;
        release_all();
        iaddr = '0; daddr = '0; dstore = '0; mem_rdata = '0;

        // Reset: no RAM request, waits follow the live request.
        step();
        step();
        iren = 1'b1; dren = 1'b1;
        sample();
        check("rst_req", 32'(mem_req), 32'h0);
        check("rst_we", 32'(mem_we), 32'h0);
        check("rst_iwait", 32'(iwait), 32'h1);
        check("rst_dwait", 32'(dwait), 32'h1);
        check("rst_iload", iload, 32'h0);
        check("rst_dload", dload, 32'h0);
        step();
        release_all();
        rst = 1'b0;
        sample();
        check("post_rst_req", 32'(mem_req), 32'h0);
        check("post_rst_err", 32'(err), 32'h0);
        check("post_rst_iwait", 32'(iwait), 32'h0);
        step();

        // Fetch from 0x10, ack one cycle after mem_req.
        preload(4, 32'h0000_0013);
        acc(1'b0, 32'h0000_0010, 1'b0, 4'b0000, 32'h0, 1);

        // Byte store to lane 2 of word 8.
        acc(1'b1, 32'h0000_0022, 1'b0, 4'b0100, 32'h00AB_0000, 1);

        // Read back to confirm the merged byte reached RAM.
        acc(1'b1, 32'h0000_0020, 1'b1, 4'b0000, 32'h0, 2);

        // Random traffic over a small address window so reads hit writes.
        for (int n = 0; n < 40; n++) begin
            is_d = 1'($urandom_range(0, 1));
            addr = 32'(($urandom_range(0, 15) << 2) | $urandom_range(0, 3));
            we   = 4'b0000;
            rd   = 1'b0;
            if (is_d) begin
                if ($urandom_range(0, 1) == 1) we = 4'($urandom);
                rd = (we == 4'b0000) ? 1'b1 : 1'($urandom_range(0, 1));
            end
            acc(is_d, addr, rd, we, $urandom, $urandom_range(1, 4));
        end

        // Simultaneous instruction and data requests: data goes first.
        vd = $urandom; vi = $urandom;
        preload(17, vd);
        preload(20, vi);
        iren = 1'b1; iaddr = 32'h50;
        dren = 1'b1; dwen = 4'b0000; daddr = 32'h44;
        sample();
        check("both_c0_req", 32'(mem_req), 32'h0);
        step();
        sample();
        check("both_c1_addr", 32'(mem_addr), 32'd17);
        check("both_c1_we", 32'(mem_we), 32'h0);
        check("both_c1_iwait", 32'(iwait), 32'h1);
        step();
        mem_ack = 1'b1; mem_rdata = rd_ram(int'(mem_addr));
        sample();
        check("both_c2_dwait", 32'(dwait), 32'h0);
        check("both_c2_dload", dload, vd);
        check("both_c2_iwait", 32'(iwait), 32'h1);
        check("both_c2_iload", iload, 32'h0);
        step();
        mem_ack = 1'b0; dren = 1'b0;
        sample();
        check("both_c3_req", 32'(mem_req), 32'h0);
        check("both_c3_iwait", 32'(iwait), 32'h1);
        step();
        sample();
        check("both_c4_addr", 32'(mem_addr), 32'd20);
        check("both_c4_iwait", 32'(iwait), 32'h1);
        step();
        mem_ack = 1'b1; mem_rdata = rd_ram(int'(mem_addr));
        sample();
        check("both_c5_iwait", 32'(iwait), 32'h0);
        check("both_c5_iload", iload, vi);
        step();
        release_all();
        sample();
        step();

        // Instruction address changes while IACC is outstanding.
        vd = $urandom; vi = $urandom;
        preload(32'h40, vd);
        preload(32'h80, vi);
        iren = 1'b1; iaddr = 32'h100;
        sample();
        step();
        sample();
        check("chg_c1_addr", 32'(mem_addr), 32'h40);
        step();
        iaddr = 32'h200;
        mem_ack = 1'b1; mem_rdata = rd_ram(int'(mem_addr));
        sample();
        check("chg_c2_iwait", 32'(iwait), 32'h1);
        check("chg_c2_iload", iload, 32'h0);
        step();
        mem_ack = 1'b0;
        sample();
        check("chg_c3_req", 32'(mem_req), 32'h0);
        step();
        sample();
        check("chg_c4_req", 32'(mem_req), 32'h1);
        check("chg_c4_addr", 32'(mem_addr), 32'h80);
        step();
        mem_ack = 1'b1; mem_rdata = rd_ram(int'(mem_addr));
        sample();
        check("chg_c5_iwait", 32'(iwait), 32'h0);
        check("chg_c5_iload", iload, vi);
        step();
        release_all();
        sample();
        step();

        // RAM never acks: timeout after TMO cycles of waiting.
        dren = 1'b1; dwen = 4'b0000; daddr = 32'h30;
        sample();
        check("tmo_c0_dwait", 32'(dwait), 32'h1);
        ok = 1'b1;
        for (int k = 1; k <= TMO; k++) begin
            step();
            sample();
            if (!(mem_req && dwait && dload == 32'h0 && !err)) ok = 1'b0;
        end
        check("tmo_window", 32'(ok), 32'h1);
        step();
        sample();
        check("tmo_dwait", 32'(dwait), 32'h0);
        check("tmo_dload", dload, 32'hDEADBEEF);
        step();
        dren = 1'b0;
        sample();
        check("tmo_req_drop", 32'(mem_req), 32'h0);
        check("tmo_err", 32'(err), 32'h1);
        step();
        mem_ack = 1'b1; mem_rdata = $urandom;
        sample();
        check("late_ack_dload", dload, 32'h0);
        check("late_ack_iload", iload, 32'h0);
        step();
        mem_ack = 1'b0;
        ok = 1'b1;
        for (int k = 0; k < 5; k++) begin
            sample();
            if (!err || mem_req) ok = 1'b0;
            step();
        end
        check("err_sticky", 32'(ok), 32'h1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        sample();
        check("err_cleared", 32'(err), 32'h0);
        step();

        // Reset in the middle of a data write, then a stray ack.
        rv = $urandom;
        dren = 1'b0; dwen = 4'hF; daddr = 32'h8; dstore = rv;
        sample();
        step();
        sample();
        check("mid_c1_req", 32'(mem_req), 32'h1);
        check("mid_c1_we", 32'(mem_we), 32'hF);
        step();
        rst = 1'b1;
        sample();
        check("mid_rst_req", 32'(mem_req), 32'h0);
        check("mid_rst_we", 32'(mem_we), 32'h0);
        check("mid_rst_dwait", 32'(dwait), 32'h1);
        check("mid_rst_dload", dload, 32'h0);
        step();
        rst = 1'b0;
        release_all();
        mem_ack = 1'b1; mem_rdata = $urandom;
        sample();
        check("mid_ack_req", 32'(mem_req), 32'h0);
        check("mid_ack_dload", dload, 32'h0);
        check("mid_ack_err", 32'(err), 32'h0);
        step();
        mem_ack = 1'b0;
        sample();
        check("mid_idle_req", 32'(mem_req), 32'h0);
        step();

        // Recovery: the abandoned write must not have landed.
        acc(1'b1, 32'h8, 1'b1, 4'b0000, 32'h0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
